// File: rtl/mem_write_ctrl.sv
// mem_write_ctrl: write-side bus sequencer downstream of mem_traverse.
// Latches a data word and the current {band,row,col} on a valid/ready accept.
// Then runs a timed CE/WE cycle (setup, strobe, hold) on the external memory.
// Finally pulses trav_step so mem_traverse moves to the next location.
// Optional feature macro: MEM_WR_CRC_EN adds crc_out, a CRC-16-CCITT running
// over every accepted word (poly 0x1021, init 0xFFFF, MSB first).
module mem_write_ctrl #(
    parameter int unsigned BAND_W     = 2,
    parameter int unsigned ROW_W      = 15,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [BAND_W-1:0]               trav_band,
    input  logic [ROW_W-1:0]                trav_row,
    input  logic [COL_W-1:0]                trav_col,
    input  logic                            trav_full,
    output logic                            trav_step,
    output logic [BAND_W+ROW_W+COL_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]               mem_data,
    output logic                            mem_ce_n,
    output logic                            mem_we_n,
    output logic                            busy,
    output logic [31:0]                     words_written,
    output logic                            overflow
`ifdef MEM_WR_CRC_EN
    ,
    output logic [15:0]                     crc_out
`endif
);

    localparam int unsigned ADDR_W = BAND_W + ROW_W + COL_W;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_STEP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                step_q, step_d;
    logic                busy_q, busy_d;
    logic [31:0]         words_q, words_d;
    logic                ovf_q, ovf_d;
    logic                accept;

`ifdef MEM_WR_CRC_EN
    logic [15:0]         crc_q, crc_d;

    // One CRC-16-CCITT update over a full data word, MSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in,
                                              input logic [DATA_W-1:0] din);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[15] ^ din[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    // enable and trav_full only matter while idle; a started write always finishes
    assign wr_ready = (state_q == S_IDLE) && enable && !trav_full;
    assign accept   = wr_valid && wr_ready;

    // Next-state and registered-output logic for the write sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_n_d  = ce_n_q;
        we_n_d  = we_n_q;
        addr_d  = addr_q;
        data_d  = data_q;
        step_d  = 1'b0;
        words_d = words_q;
        ovf_d   = ovf_q;
`ifdef MEM_WR_CRC_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wr_valid && enable && trav_full) begin
                    ovf_d = 1'b1;
                end
                if (accept) begin
                    data_d  = wr_data;
                    addr_d  = {trav_band, trav_row, trav_col};
                    ce_n_d  = 1'b0;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = S_SETUP;
`ifdef MEM_WR_CRC_EN
                    crc_d   = crc16_upd(crc_q, wr_data);
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b0;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    ce_n_d  = 1'b1;
                    step_d  = 1'b1;
                    state_d = S_STEP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STEP: begin
                if (words_q != 32'hFFFF_FFFF) begin
                    words_d = words_q + 32'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ce_n_d  = 1'b1;
                we_n_d  = 1'b1;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops CE/WE immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= ce_n_d;
            we_n_q  <= we_n_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MEM_WR_CRC_EN
    // Running CRC over accepted words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;
`endif

    assign trav_step     = step_q;
    assign mem_addr      = addr_q;
    assign mem_data      = data_q;
    assign mem_ce_n      = ce_n_q;
    assign mem_we_n      = we_n_q;
    assign busy          = busy_q;
    assign words_written = words_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// tb_mem_write_ctrl: directed self-checking bench for mem_write_ctrl.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Build with MEM_WR_CRC_EN defined to include the CRC checks.
module tb_mem_write_ctrl;

    localparam int unsigned BAND_W = 2;
    localparam int unsigned ROW_W  = 15;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = BAND_W + ROW_W + COL_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [BAND_W-1:0] trav_band;
    logic [ROW_W-1:0]  trav_row;
    logic [COL_W-1:0]  trav_col;
    logic              trav_full;
    logic              trav_step;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ce_n;
    logic              mem_we_n;
    logic              busy;
    logic [31:0]       words_written;
    logic              overflow;
`ifdef MEM_WR_CRC_EN
    logic [15:0]       crc_out;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_write_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .trav_band     (trav_band),
        .trav_row      (trav_row),
        .trav_col      (trav_col),
        .trav_full     (trav_full),
        .trav_step     (trav_step),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_ce_n      (mem_ce_n),
        .mem_we_n      (mem_we_n),
        .busy          (busy),
        .words_written (words_written),
        .overflow      (overflow)
`ifdef MEM_WR_CRC_EN
        ,
        .crc_out       (crc_out)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Present one word for a single cycle; returns on the falling edge after the accept edge.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic [BAND_W-1:0] b,
                             input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        wr_data   = d;
        trav_band = b;
        trav_row  = r;
        trav_col  = c;
        wr_valid  = 1'b1;
        tick();
        wr_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) chk(tag, 64'(busy), 64'd0);
    endtask

`ifdef MEM_WR_CRC_EN
    // Byte-at-a-time CRC-16-CCITT reference.
    function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [15:0] w);
        logic [15:0] c;
        logic [7:0]  bytes [2];
        c = c_in;
        bytes[0] = w[15:8];
        bytes[1] = w[7:0];
        for (int k = 0; k < 2; k++) begin
            c = c ^ {bytes[k], 8'h00};
            for (int b = 0; b < 8; b++) begin
                if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else       c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    initial begin
        logic [5:0] ce_v, we_v, st_v, rdy_v, bsy_v;
        int acc [4];
        int nacc, steps, ce_low;

        rst_n = 1'b0; enable = 1'b1; wr_data = '0; wr_valid = 1'b0;
        trav_band = '0; trav_row = '0; trav_col = '0; trav_full = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_ce_n",  64'(mem_ce_n), 64'd1);
        chk("rst_we_n",  64'(mem_we_n), 64'd1);
        chk("rst_addr",  64'(mem_addr), 64'd0);
        chk("rst_data",  64'(mem_data), 64'd0);
        chk("rst_step",  64'(trav_step), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
`ifdef MEM_WR_CRC_EN
        chk("rst_crc",   64'(crc_out), 64'hFFFF);
`endif
        do_reset();
        chk("idle_ready", 64'(wr_ready), 64'd1);

        // Single write: per-cycle waveform after the accept edge
        send_word(16'hA5A5, 2'b01, 15'h0003, 10'h010);
        for (int j = 0; j < 6; j++) begin
            ce_v[j]  = mem_ce_n;
            we_v[j]  = mem_we_n;
            st_v[j]  = trav_step;
            rdy_v[j] = wr_ready;
            bsy_v[j] = busy;
            if (j < 5) tick();
        end
        chk("w1_ce_n",  64'(ce_v),  64'(6'b110000));
        chk("w1_we_n",  64'(we_v),  64'(6'b111001));
        chk("w1_step",  64'(st_v),  64'(6'b010000));
        chk("w1_ready", 64'(rdy_v), 64'(6'b100000));
        chk("w1_busy",  64'(bsy_v), 64'(6'b011111));
        chk("w1_addr",  64'(mem_addr), 64'({2'b01, 15'h0003, 10'h010}));
        chk("w1_data",  64'(mem_data), 64'hA5A5);
        chk("w1_words", 64'(words_written), 64'd1);
`ifdef MEM_WR_CRC_EN
        // Single word 0xA5A5 was not the CRC plan; restart from reset for it.
        do_reset();
        send_word(16'h0000, 2'b00, 15'h0000, 10'h000);
        wait_idle("crc0_timeout");
        chk("crc_zero", 64'(crc_out), 64'h1D0F);
        send_word(16'h1234, 2'b00, 15'h0000, 10'h001);
        wait_idle("crc1_timeout");
        chk("crc_1234", 64'(crc_out), 64'(ref_crc(16'h1D0F, 16'h1234)));
`endif

        // Back-to-back words with wr_valid held high
        do_reset();
        wr_data = 16'h1111; trav_band = 2'b10; trav_row = 15'h0100;
        wr_valid = 1'b1;
        nacc = 0; steps = 0;
        for (int i = 0; i < 30; i++) begin
            if (nacc == 4) wr_valid = 1'b0;
            trav_col = COL_W'(nacc);
            if (wr_valid && wr_ready) begin
                acc[nacc] = i;
                nacc++;
            end
            if (trav_step) steps++;
            tick();
        end
        chk("b2b_accepts", 64'(nacc), 64'd4);
        chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'd6);
        chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'd6);
        chk("b2b_gap3", 64'(acc[3] - acc[2]), 64'd6);
        chk("b2b_steps", 64'(steps), 64'd4);
        chk("b2b_words", 64'(words_written), 64'd4);
        chk("b2b_col", 64'(mem_addr[COL_W-1:0]), 64'd3);

        // enable low: offered word ignored, no overflow
        do_reset();
        enable = 1'b0; trav_full = 1'b1; wr_valid = 1'b1;
        ce_low = 0;
        for (int i = 0; i < 3; i++) begin
            if (!mem_ce_n) ce_low++;
            tick();
        end
        chk("dis_ready", 64'(wr_ready), 64'd0);
        chk("dis_ce", 64'(ce_low), 64'd0);
        chk("dis_ovf", 64'(overflow), 64'd0);

        // Memory full: refused, overflow sticky
        enable = 1'b1;
        chk("full_ready", 64'(wr_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!mem_ce_n) ce_low++;
        end
        chk("full_ce", 64'(ce_low), 64'd0);
        chk("full_ovf", 64'(overflow), 64'd1);
        trav_full = 1'b0; wr_valid = 1'b0;
        tick();
        tick();
        chk("full_ovf_sticky", 64'(overflow), 64'd1);
        chk("full_words", 64'(words_written), 64'd0);

        // Drop enable mid-strobe: current write completes, nothing new starts
        do_reset();
        send_word(16'h5A5A, 2'b11, 15'h7FFF, 10'h3FF);
        tick();
        chk("en_strobe_we", 64'(mem_we_n), 64'd0);
        enable = 1'b0; wr_valid = 1'b1;
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (trav_step) steps++;
        end
        chk("en_steps", 64'(steps), 64'd1);
        chk("en_words", 64'(words_written), 64'd1);
        chk("en_ce_idle", 64'(mem_ce_n), 64'd1);
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_addr", 64'(mem_addr), 64'({2'b11, 15'h7FFF, 10'h3FF}));
        wr_valid = 1'b0; enable = 1'b1;

        // Asynchronous reset during strobe
        send_word(16'h0F0F, 2'b00, 15'h0001, 10'h002);
        tick();
        chk("ar_we_before", 64'(mem_we_n), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("ar_we_n", 64'(mem_we_n), 64'd1);
        chk("ar_ce_n", 64'(mem_ce_n), 64'd1);
        chk("ar_words", 64'(words_written), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        steps = 0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (trav_step) steps++;
            tick();
        end
        chk("ar_steps", 64'(steps), 64'd0);
        chk("ar_addr", 64'(mem_addr), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
